// File: rtl/snake_pkg.sv
`default_nettype none
// =============================================================================
// snake_pkg : shared direction/state encodings and cell helpers
// Revision  : 1.0
// =============================================================================
package snake_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // UP<->DOWN and RIGHT<->LEFT differ only in bit 1
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

  function automatic logic [2*COORD_W-1:0] pack_cell(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [COORD_W-1:0] cell_x(input logic [2*COORD_W-1:0] c);
    return c[2*COORD_W-1:COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] cell_y(input logic [2*COORD_W-1:0] c);
    return c[COORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_step_ctrl_if.sv
`default_nettype none
// =============================================================================
// snake_step_ctrl_if : game-step inputs, body-FIFO strobes and status outputs
// Revision           : 1.0
// =============================================================================
interface snake_step_ctrl_if #(
  parameter int COORD_W    = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 7
);
  logic                  tick;
  logic                  dir_valid;
  logic [1:0]            dir_req;
  logic                  grow;
  logic                  fifo_empty;
  logic                  fifo_write;
  logic                  fifo_read;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [COORD_W-1:0]    head_x;
  logic [COORD_W-1:0]    head_y;
  logic [LEN_W-1:0]      length;
  logic                  step_done;
  logic                  game_over;

  modport master (
    input  tick, dir_valid, dir_req, grow, fifo_empty,
    output fifo_write, fifo_read, fifo_wdata, head_x, head_y, length,
           step_done, game_over
  );

  modport slave (
    output tick, dir_valid, dir_req, grow, fifo_empty,
    input  fifo_write, fifo_read, fifo_wdata, head_x, head_y, length,
           step_done, game_over
  );
endinterface
`default_nettype wire

// File: rtl/snake_next_head.sv
`default_nettype none
// =============================================================================
// snake_next_head : combinational next-head cell with wall detect or wrap
// Revision        : 1.0
// =============================================================================
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int COORD_W = snake_pkg::COORD_W
) (
  input  logic [COORD_W-1:0] head_x_i,
  input  logic [COORD_W-1:0] head_y_i,
  input  dir_t               dir_i,
  input  logic               wrap_i,
  output logic [COORD_W-1:0] next_x_o,
  output logic [COORD_W-1:0] next_y_o,
  output logic               out_of_range_o
);

  localparam logic signed [COORD_W:0] C_GRID_W = (COORD_W+1)'(GRID_W);
  localparam logic signed [COORD_W:0] C_GRID_H = (COORD_W+1)'(GRID_H);
  localparam logic signed [COORD_W:0] C_ONE    = (COORD_W+1)'(1);
  localparam logic signed [COORD_W:0] C_ZERO   = '0;

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic signed [COORD_W:0] w_x;
  logic signed [COORD_W:0] w_y;
  logic                    w_x_lo;
  logic                    w_x_hi;
  logic                    w_y_lo;
  logic                    w_y_hi;

  always_comb begin
    w_dx = C_ZERO;
    w_dy = C_ZERO;
    unique case (dir_i)
      DIR_UP:    w_dy = -C_ONE;
      DIR_RIGHT: w_dx = C_ONE;
      DIR_DOWN:  w_dy = C_ONE;
      DIR_LEFT:  w_dx = -C_ONE;
      default:   ;
    endcase
    // One extra bit so a step below zero shows up as a negative value
    w_x = $signed({1'b0, head_x_i}) + w_dx;
    w_y = $signed({1'b0, head_y_i}) + w_dy;

    w_x_lo = w_x[COORD_W];
    w_y_lo = w_y[COORD_W];
    w_x_hi = !w_x_lo && (w_x >= C_GRID_W);
    w_y_hi = !w_y_lo && (w_y >= C_GRID_H);

    next_x_o = w_x[COORD_W-1:0];
    next_y_o = w_y[COORD_W-1:0];
    if (wrap_i && w_x_lo) next_x_o = COORD_W'(GRID_W - 1);
    if (wrap_i && w_x_hi) next_x_o = '0;
    if (wrap_i && w_y_lo) next_y_o = COORD_W'(GRID_H - 1);
    if (wrap_i && w_y_hi) next_y_o = '0;

    out_of_range_o = !wrap_i && (w_x_lo || w_x_hi || w_y_lo || w_y_hi);
  end

endmodule
`default_nettype wire

// File: rtl/snake_step_ctrl.sv
`default_nettype none
// =============================================================================
// snake_step_ctrl : per-tick snake movement, body-FIFO push/pop, game over
// Revision        : 1.0
// =============================================================================
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 24,
  parameter int COORD_W    = snake_pkg::COORD_W,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 64,
  parameter int INIT_LEN   = 3,
  parameter int START_X    = 16,
  parameter int START_Y    = 12,
  parameter int WRAP       = 0
) (
  input logic              clk,
  input logic              rst,
  snake_step_ctrl_if.master bus
);

  localparam int                 LEN_W       = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0]   C_MAX_LEN   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   C_INIT_LAST = LEN_W'(INIT_LEN - 1);
  localparam logic [COORD_W-1:0] C_START_X   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] C_START_Y   = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] C_TAIL_X    = COORD_W'(START_X - INIT_LEN + 1);
  localparam logic               C_WRAP      = (WRAP != 0);

  state_t                state_q;
  logic [LEN_W-1:0]      init_cnt_q;
  logic [COORD_W-1:0]    head_x_q;
  logic [COORD_W-1:0]    head_y_q;
  logic [LEN_W-1:0]      len_q;
  dir_t                  dir_q;
  dir_t                  pend_dir_q;
  logic                  grow_q;
  logic                  fifo_write_q;
  logic                  fifo_read_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  step_done_q;
  logic                  game_over_q;

  dir_t                  w_pend_dir;
  logic                  w_grow;
  logic [COORD_W-1:0]    w_next_x;
  logic [COORD_W-1:0]    w_next_y;
  logic                  w_oor;
  logic [COORD_W-1:0]    w_init_x;

  // A same-cycle request is visible to a coinciding tick
  always_comb begin
    w_pend_dir = pend_dir_q;
    if (bus.dir_valid && (dir_t'(bus.dir_req) != opposite(dir_q)))
      w_pend_dir = dir_t'(bus.dir_req);
  end

  assign w_grow   = bus.grow | grow_q;
  assign w_init_x = C_TAIL_X + COORD_W'(init_cnt_q);

  snake_next_head #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .COORD_W (COORD_W)
  ) u_next_head (
    .head_x_i       (head_x_q),
    .head_y_i       (head_y_q),
    .dir_i          (w_pend_dir),
    .wrap_i         (C_WRAP),
    .next_x_o       (w_next_x),
    .next_y_o       (w_next_y),
    .out_of_range_o (w_oor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      head_x_q     <= C_START_X;
      head_y_q     <= C_START_Y;
      len_q        <= '0;
      dir_q        <= DIR_RIGHT;
      pend_dir_q   <= DIR_RIGHT;
      grow_q       <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_read_q  <= 1'b0;
      wdata_q      <= '0;
      step_done_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      fifo_write_q <= 1'b0;
      fifo_read_q  <= 1'b0;
      step_done_q  <= 1'b0;
      unique case (state_q)
        ST_INIT: begin
          pend_dir_q   <= w_pend_dir;
          grow_q       <= w_grow;
          fifo_write_q <= 1'b1;
          wdata_q      <= pack_cell(w_init_x, C_START_Y);
          len_q        <= len_q + 1'b1;
          init_cnt_q   <= init_cnt_q + 1'b1;
          if (init_cnt_q == C_INIT_LAST) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          pend_dir_q <= w_pend_dir;
          grow_q     <= w_grow;
          if (bus.tick) begin
            if (w_oor) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              dir_q        <= w_pend_dir;
              head_x_q     <= w_next_x;
              head_y_q     <= w_next_y;
              fifo_write_q <= 1'b1;
              wdata_q      <= pack_cell(w_next_x, w_next_y);
              step_done_q  <= 1'b1;
              grow_q       <= 1'b0;
              // At full length a grow is consumed as a plain move
              if (w_grow && (len_q < C_MAX_LEN)) len_q <= len_q + 1'b1;
              else                               fifo_read_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_read  = fifo_read_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.head_x     = head_x_q;
  assign bus.head_y     = head_y_q;
  assign bus.length     = len_q;
  assign bus.step_done  = step_done_q;
  assign bus.game_over  = game_over_q;

  a_read_not_empty: assert property (@(posedge clk) disable iff (rst)
    bus.fifo_read |-> !bus.fifo_empty);

endmodule
`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
`default_nettype none
// =============================================================================
// tb_snake_step_ctrl : scoreboard bench for snake_step_ctrl (wall and wrap)
// Revision           : 1.0
// =============================================================================
module tb_snake_step_ctrl;
  import snake_pkg::*;

  typedef struct packed {
    logic        w;
    logic        r;
    logic [15:0] d;
    logic        sd;
    logic [7:0]  hx;
    logic [7:0]  hy;
    logic [6:0]  len;
    logic        go;
  } ev_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst1 = 1'b1;
  logic fifo_rst_n;
  logic fifo_rst1_n;
  always #5 clk = ~clk;
  assign fifo_rst_n  = ~rst;
  assign fifo_rst1_n = ~rst1;

  snake_step_ctrl_if bus0 ();
  snake_step_ctrl_if bus1 ();

  snake_step_ctrl #(.WRAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  snake_step_ctrl #(.START_X(31), .WRAP(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.master));

  // Body FIFO models, cleared by the same reset event
  logic [15:0] fq0[$];
  logic [15:0] fq1[$];
  logic [7:0]  fcnt0 = '0;
  logic [7:0]  fcnt1 = '0;
  assign bus0.fifo_empty = (fcnt0 == 8'd0);
  assign bus1.fifo_empty = (fcnt1 == 8'd0);

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      fq0.delete();
      fcnt0 <= '0;
    end else begin
      if (bus0.fifo_read && fq0.size() > 0) void'(fq0.pop_front());
      if (bus0.fifo_write) fq0.push_back(bus0.fifo_wdata);
      fcnt0 <= 8'(fq0.size());
    end
  end

  always @(posedge clk or negedge fifo_rst1_n) begin
    if (!fifo_rst1_n) begin
      fq1.delete();
      fcnt1 <= '0;
    end else begin
      if (bus1.fifo_read && fq1.size() > 0) void'(fq1.pop_front());
      if (bus1.fifo_write) fq1.push_back(bus1.fifo_wdata);
      fcnt1 <= 8'(fq1.size());
    end
  end

  ev_t sb0[$];
  ev_t sb1[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  function automatic ev_t mk(input logic w, input logic r, input logic [15:0] d,
                             input logic sd, input int hx, input int hy,
                             input int len, input logic go);
    ev_t e;
    e.w = w; e.r = r; e.d = w ? d : 16'h0; e.sd = sd;
    e.hx = 8'(hx); e.hy = 8'(hy); e.len = 7'(len); e.go = go;
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("w=%0b r=%0b d=%h sd=%0b head=(%0d,%0d) len=%0d go=%0b",
                     e.w, e.r, e.d, e.sd, e.hx, e.hy, e.len, e.go);
  endfunction

  task automatic cmp_ev(input string nm, input ev_t got, input ev_t exp, input bit have);
    n_chk++;
    if (have && got === exp) n_pass++;
    else if (have) $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(exp));
    else           $display("FAIL %s: got %s, want no output", nm, fmt(got));
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  // Monitors: every presented output pops one expectation
  logic go0_q = 1'b0;
  logic go1_q = 1'b0;
  ev_t  g0, g1;

  always @(negedge clk) begin
    if (!rst && (bus0.fifo_write || bus0.fifo_read || bus0.step_done ||
                 (bus0.game_over && !go0_q))) begin
      g0 = mk(bus0.fifo_write, bus0.fifo_read, bus0.fifo_wdata, bus0.step_done,
              int'(bus0.head_x), int'(bus0.head_y), int'(bus0.length), bus0.game_over);
      if (sb0.size() > 0) cmp_ev("dut0_event", g0, sb0.pop_front(), 1'b1);
      else                cmp_ev("dut0_unexpected", g0, g0, 1'b0);
    end
    go0_q <= bus0.game_over;
  end

  always @(negedge clk) begin
    if (!rst1 && (bus1.fifo_write || bus1.fifo_read || bus1.step_done ||
                  (bus1.game_over && !go1_q))) begin
      g1 = mk(bus1.fifo_write, bus1.fifo_read, bus1.fifo_wdata, bus1.step_done,
              int'(bus1.head_x), int'(bus1.head_y), int'(bus1.length), bus1.game_over);
      if (sb1.size() > 0) cmp_ev("dut1_event", g1, sb1.pop_front(), 1'b1);
      else                cmp_ev("dut1_unexpected", g1, g1, 1'b0);
    end
    go1_q <= bus1.game_over;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input logic g, input logic dv, input logic [1:0] d,
                       input ev_t e, input bit expect_ev);
    if (expect_ev) sb0.push_back(e);
    bus0.tick = 1'b1; bus0.grow = g; bus0.dir_valid = dv; bus0.dir_req = d;
    cyc();
    bus0.tick = 1'b0; bus0.grow = 1'b0; bus0.dir_valid = 1'b0;
  endtask

  task automatic pulse0(input logic g, input logic dv, input logic [1:0] d);
    bus0.grow = g; bus0.dir_valid = dv; bus0.dir_req = d;
    cyc();
    bus0.grow = 1'b0; bus0.dir_valid = 1'b0;
  endtask

  task automatic push_init0();
    for (int i = 0; i < 3; i++)
      sb0.push_back(mk(1, 0, {8'(14 + i), 8'd12}, 0, 16, 12, i + 1, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus0.tick = 0; bus0.dir_valid = 0; bus0.dir_req = 2'd0; bus0.grow = 0;
    bus1.tick = 0; bus1.dir_valid = 0; bus1.dir_req = 2'd0; bus1.grow = 0;

    cyc();
    chk("rst_head_x", int'(bus0.head_x), 16);
    chk("rst_head_y", int'(bus0.head_y), 12);
    chk("rst_length", int'(bus0.length), 0);
    chk("rst_strobes", int'({bus0.fifo_write, bus0.fifo_read, bus0.step_done, bus0.game_over}), 0);

    push_init0();
    for (int i = 0; i < 3; i++)
      sb1.push_back(mk(1, 0, {8'(29 + i), 8'd12}, 0, 31, 12, i + 1, 0));

    cyc();
    rst = 1'b0; rst1 = 1'b0;
    bus0.tick = 1'b1;           // must be ignored while initialising
    cyc();
    bus0.tick = 1'b0;
    repeat (3) cyc();
    chk("init_fifo_count0", fq0.size(), 3);
    chk("init_fifo_count1", fq1.size(), 3);

    step0(0, 0, DIR_UP, mk(1, 1, 16'h110C, 1, 17, 12, 3, 0), 1);
    pulse0(0, 1, DIR_LEFT);
    step0(0, 0, DIR_UP, mk(1, 1, 16'h120C, 1, 18, 12, 3, 0), 1);
    pulse0(0, 1, DIR_UP);
    step0(0, 0, DIR_UP, mk(1, 1, 16'h120B, 1, 18, 11, 3, 0), 1);
    pulse0(1, 0, DIR_UP);
    step0(0, 0, DIR_UP, mk(1, 0, 16'h120A, 1, 18, 10, 4, 0), 1);
    step0(0, 0, DIR_UP, mk(1, 1, 16'h1209, 1, 18, 9, 4, 0), 1);
    // grow and turn on the same cycle as the tick
    step0(1, 1, DIR_RIGHT, mk(1, 0, 16'h1309, 1, 19, 9, 5, 0), 1);
    for (int x = 20; x <= 31; x++)
      step0(0, 0, DIR_UP, mk(1, 1, {8'(x), 8'h09}, 1, x, 9, 5, 0), 1);
    step0(0, 0, DIR_UP, mk(0, 0, 16'h0, 0, 31, 9, 5, 1), 1);
    step0(1, 1, DIR_DOWN, mk(0, 0, 16'h0, 0, 0, 0, 0, 0), 0);
    step0(0, 0, DIR_UP, mk(0, 0, 16'h0, 0, 0, 0, 0, 0), 0);
    cyc();
    chk("over_sticky", int'(bus0.game_over), 1);
    chk("over_head_x", int'(bus0.head_x), 31);
    chk("over_length", int'(bus0.length), 5);
    chk("over_fifo_count", fq0.size(), 5);

    sb1.push_back(mk(1, 1, 16'h000C, 1, 0, 12, 3, 0));
    bus1.tick = 1'b1;
    cyc();
    bus1.tick = 1'b0;
    cyc();

    // Restart dut0 and grow it to length 10
    rst = 1'b1;
    cyc();
    push_init0();
    rst = 1'b0;
    repeat (4) cyc();
    for (int k = 0; k < 7; k++)
      step0(1, 0, DIR_UP, mk(1, 0, {8'(17 + k), 8'd12}, 1, 17 + k, 12, 4 + k, 0), 1);
    cyc();
    chk("grown_length", int'(bus0.length), 10);
    chk("grown_fifo_count", fq0.size(), 10);

    #2 rst = 1'b1;              // between clock edges
    #1;
    chk("async_head", int'({bus0.head_x, bus0.head_y}), 16'h100C);
    chk("async_length", int'(bus0.length), 0);
    chk("async_strobes", int'({bus0.fifo_write, bus0.fifo_read, bus0.step_done, bus0.game_over}), 0);
    chk("async_fifo_count", fq0.size(), 0);

    cyc();
    push_init0();
    rst = 1'b0;
    repeat (5) cyc();
    chk("reinit_fifo_count", fq0.size(), 3);
    chk("reinit_length", int'(bus0.length), 3);

    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
